// File: rtl/regfile_initiator_pkg.sv
// Shared types and default widths for the register-file initiator.
package regfile_initiator_pkg;

    localparam int unsigned DEF_ADDR_W = 3;
    localparam int unsigned DEF_DATA_W = 1;

    // Command-holding FSM: IDLE holds nothing, PEND_* holds one command awaiting issue.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND_WR = 2'd1,
        PEND_RD = 2'd2
    } state_t;

endpackage

// File: rtl/regfile_initiator_rsp_fifo.sv
// Synchronous response FIFO: {address, data} entries, depth a power of two.
module rsp_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage write; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keeps count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/regfile_initiator.sv
// Register-file initiator: holds one command, issues it to the target's
// write/read method when ready, and queues read responses in order.
module regfile_initiator
    import regfile_initiator_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned RSP_DEPTH = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_is_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              write_en,
    input  logic              write_rdy,
    output logic [ADDR_W-1:0] read_address,
    output logic              read_en,
    input  logic [DATA_W-1:0] read_data,
    input  logic              read_rdy,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count,
    output logic              busy
);

    localparam int unsigned FCW = $clog2(RSP_DEPTH) + 1;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   hold_addr;
    logic [DATA_W-1:0]   hold_data;
    logic                issue_wr;
    logic                issue_rd;
    logic                accept;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FCW-1:0]      fifo_count;
    logic [ADDR_W+DATA_W-1:0] fifo_head;

    // State register; reset discards any held command.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Issue conditions, handshake outputs and next state.
    always_comb begin
        issue_wr  = 1'b0;
        issue_rd  = 1'b0;
        state_nxt = state;
        case (state)
            PEND_WR: issue_wr = write_rdy;
            PEND_RD: issue_rd = read_rdy && !fifo_full;
            default: ;
        endcase
        cmd_ready = (state == IDLE) || issue_wr || issue_rd;
        accept    = cmd_valid && cmd_ready;
        write_en  = issue_wr;
        read_en   = issue_rd;
        if (accept) begin
            state_nxt = cmd_is_write ? PEND_WR : PEND_RD;
        end else if (issue_wr || issue_rd) begin
            state_nxt = IDLE;
        end
    end

    // Holding register captures the accepted command; target buses read from it.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            hold_addr <= '0;
            hold_data <= '0;
        end else if (accept) begin
            hold_addr <= cmd_addr;
            hold_data <= cmd_wdata;
        end
    end

    assign write_address = hold_addr;
    assign write_data    = hold_data;
    assign read_address  = hold_addr;

    // Issued-transaction counters, wrapping at 2^CNT_W.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (issue_wr) wr_count <= wr_count + 1'b1;
            if (issue_rd) rd_count <= rd_count + 1'b1;
        end
    end

    rsp_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (issue_rd),
        .push_data ({read_address, read_data}),
        .pop       (rsp_valid && rsp_ready),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_addr  = fifo_head[ADDR_W+DATA_W-1:DATA_W];
    assign rsp_data  = fifo_head[DATA_W-1:0];
    assign busy      = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_regfile_initiator.sv
// Self-checking bench: directed scenarios then a random stream, all checked
// against a queue-based transaction model.
module tb_regfile_initiator;

    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 1;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 8;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          cmd_valid, cmd_ready, cmd_is_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [AW-1:0] write_address, read_address, rsp_addr;
    logic [DW-1:0] write_data, read_data, rsp_data;
    logic          write_en, write_rdy, read_en, read_rdy;
    logic          rsp_valid, rsp_ready, busy;
    logic [CW-1:0] wr_count, rd_count;

    always #5 CLK = ~CLK;

    regfile_initiator #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RSP_DEPTH (DEPTH),
        .CNT_W     (CW)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_is_write  (cmd_is_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_data     (read_data),
        .read_rdy      (read_rdy),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_addr      (rsp_addr),
        .rsp_data      (rsp_data),
        .wr_count      (wr_count),
        .rd_count      (rd_count),
        .busy          (busy)
    );

    int checks = 0;
    int errors = 0;

    // Transaction model: one optional held command plus an ordered response queue.
    bit                 m_have;
    bit                 m_w;
    logic [AW-1:0]      m_addr;
    logic [DW-1:0]      m_data;
    logic [AW+DW-1:0]   rq[$];
    int unsigned        m_wc;
    int unsigned        m_rc;
    logic [DW-1:0]      tgt [2**AW];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_have = 1'b0;
        rq.delete();
        m_wc = 0;
        m_rc = 0;
    endtask

    // One clock cycle: drive, check outputs against the model, clock, update model.
    task automatic cycle(input bit rst, input bit cv, input bit iw,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit wr, input bit rr, input bit rspr);
        bit e_wen, e_ren, e_rdy, e_rv;
        RST_N        = rst;
        cmd_valid    = cv;
        cmd_is_write = iw;
        cmd_addr     = a;
        cmd_wdata    = d;
        write_rdy    = wr;
        read_rdy     = rr;
        rsp_ready    = rspr;
        read_data    = (m_have && !m_w) ? tgt[m_addr] : DW'($urandom);
        #1;
        e_wen = m_have && m_w && wr;
        e_ren = m_have && !m_w && rr && (rq.size() < DEPTH);
        e_rdy = !m_have || e_wen || e_ren;
        e_rv  = (rq.size() != 0);
        chk("write_en", 32'(write_en), 32'(e_wen));
        chk("read_en", 32'(read_en), 32'(e_ren));
        if (rst) chk("cmd_ready", 32'(cmd_ready), 32'(e_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        chk("busy", 32'(busy), 32'(m_have || e_rv));
        chk("wr_count", 32'(wr_count), m_wc % 256);
        chk("rd_count", 32'(rd_count), m_rc % 256);
        if (m_have && m_w) begin
            chk("write_address", 32'(write_address), 32'(m_addr));
            chk("write_data", 32'(write_data), 32'(m_data));
        end
        if (m_have && !m_w) chk("read_address", 32'(read_address), 32'(m_addr));
        if (e_rv) begin
            chk("rsp_addr", 32'(rsp_addr), 32'(rq[0][AW+DW-1:DW]));
            chk("rsp_data", 32'(rsp_data), 32'(rq[0][DW-1:0]));
        end
        @(posedge CLK);
        if (!rst) begin
            model_reset();
        end else begin
            if (e_rv && rspr) void'(rq.pop_front());
            if (e_ren) rq.push_back({m_addr, read_data});
            if (e_wen) m_wc++;
            if (e_ren) m_rc++;
            if (cv && e_rdy) begin
                m_have = 1'b1;
                m_w    = iw;
                m_addr = a;
                m_data = d;
            end else if (e_wen || e_ren) begin
                m_have = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        RST_N = 1'b0; cmd_valid = 0; cmd_is_write = 0; cmd_addr = '0; cmd_wdata = '0;
        write_rdy = 0; read_rdy = 0; read_data = '0; rsp_ready = 0;
        for (int i = 0; i < 2**AW; i++) tgt[i] = DW'($urandom);
        tgt[0] = 1'b1; tgt[1] = 1'b0; tgt[2] = 1'b1;
        @(posedge CLK);
        #1;
        model_reset();

        // Reset state, with ready inputs high to show nothing is issued.
        cycle(0, 1, 1, 3'd1, 1'b1, 1, 1, 1);
        cycle(0, 0, 0, 3'd0, 1'b0, 1, 1, 1);
        cycle(1, 0, 0, 3'd0, 1'b0, 1, 1, 1);

        // Single write to address 5, data 1, target ready.
        cycle(1, 1, 1, 3'd5, 1'b1, 1, 0, 0);
        cycle(1, 0, 0, 3'd0, 1'b0, 1, 0, 0);
        cycle(1, 0, 0, 3'd0, 1'b0, 1, 0, 0);
        chk("wr_count_single", 32'(wr_count), 32'd1);

        // Write held by write_rdy low for 4 cycles while another command is offered.
        cycle(1, 1, 1, 3'd3, 1'b0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 3'd7, 1'b1, 0, 1, 0);
        cycle(1, 0, 0, 3'd0, 1'b0, 1, 0, 0);
        cycle(1, 0, 0, 3'd0, 1'b0, 1, 0, 0);

        // Back-to-back reads 0,1,2 with responses blocked, then drained in order.
        cycle(1, 1, 0, 3'd0, 1'b0, 0, 1, 0);
        cycle(1, 1, 0, 3'd1, 1'b0, 0, 1, 0);
        cycle(1, 1, 0, 3'd2, 1'b0, 0, 1, 0);
        cycle(1, 0, 0, 3'd0, 1'b0, 0, 1, 0);
        cycle(1, 0, 0, 3'd0, 1'b0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 3'd0, 1'b0, 0, 1, 1);

        // Reset while a read is pending and two responses are queued.
        cycle(1, 1, 0, 3'd3, 1'b0, 0, 1, 0);
        cycle(1, 1, 0, 3'd4, 1'b0, 0, 1, 0);
        cycle(1, 1, 0, 3'd5, 1'b0, 0, 1, 0);
        cycle(1, 0, 0, 3'd0, 1'b0, 0, 1, 0);
        cycle(0, 0, 0, 3'd0, 1'b0, 0, 1, 0);
        cycle(1, 0, 0, 3'd0, 1'b0, 1, 1, 1);
        chk("rsp_valid_after_reset", 32'(rsp_valid), 32'd0);
        chk("rd_count_after_reset", 32'(rd_count), 32'd0);

        // Counter wrap: 255 writes, then one more.
        for (int i = 0; i < 255; i++) cycle(1, 1, 1, AW'(i), DW'(i), 1, 0, 0);
        cycle(1, 0, 0, 3'd0, 1'b0, 1, 0, 0);
        chk("wr_count_255", 32'(wr_count), 32'd255);
        cycle(1, 1, 1, 3'd6, 1'b1, 1, 0, 0);
        cycle(1, 0, 0, 3'd0, 1'b0, 1, 0, 0);
        chk("wr_count_wrap", 32'(wr_count), 32'd0);

        // Random command stream with random readiness and one reset in the middle.
        for (int i = 0; i < 2**AW; i++) tgt[i] = DW'($urandom);
        for (int i = 0; i < 1500; i++) begin
            cycle((i != 750), ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
                  AW'($urandom), DW'($urandom),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
                  $urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 3'd0, 1'b0, 1, 1, 1);
        chk("idle_at_end", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
